// File: rtl/mem_interface.sv
// ---------------------------------------------------------------------------
// mem_interface
//
// Memory-side stage that sits directly upstream of the datapath's MDR input
// mux. It holds the Memory Address Register (MAR), which is loaded from the
// shared bus, and a word-addressed internal RAM. Read and Write requests run
// as multi-cycle transactions with WAIT_STATES extra cycles before the RAM
// access. Each transaction ends with a one-cycle mem_done pulse, which tells
// the control sequencer when to assert MDRin.
//
// Parameters
//   DATA_W      : word width of the bus, the MDR and the RAM
//   ADDR_W      : RAM index width (depth = 2**ADDR_W words); must be < DATA_W
//   WAIT_STATES : extra cycles before each RAM access (0..15)
//
// Ports
//   clk          in   system clock, rising edge
//   clr          in   synchronous active-high reset (RAM contents are kept)
//   bus_contents in   bus value, loaded into MAR on MARin (IDLE only)
//   MARin        in   load MAR from bus_contents
//   MDR_data_out in   write data, captured when a Write is accepted
//   Read         in   read request, sampled in IDLE only
//   Write        in   write request, sampled in IDLE only
//   MDatain      out  read-data latch feeding the MDR mux
//   MAR_data_out out  current MAR contents
//   mem_busy     out  high while a transaction is in WAIT or DONE
//   mem_done     out  one-cycle completion pulse
//   addr_err     out  one-cycle error pulse, coincident with mem_done
//
// Build option
//   MEM_PRELOAD_EN : when defined, the RAM starts with the preload image
//                    (word 0 = 0x00000A5A). Words not listed are zero.
//                    When undefined, the RAM starts as all zeros.
// ---------------------------------------------------------------------------
module mem_interface #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] bus_contents,
    input  logic              MARin,
    input  logic [DATA_W-1:0] MDR_data_out,
    input  logic              Read,
    input  logic              Write,
    output logic [DATA_W-1:0] MDatain,
    output logic [DATA_W-1:0] MAR_data_out,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              addr_err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                op_wr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   mar_q;
    logic [DATA_W-1:0]   mdat_q;
    logic                busy_q;
    logic                done_q;
    logic                aerr_q;

    logic [DATA_W-1:0]   ram_q [0:DEPTH-1];

    logic [ADDR_W-1:0]   ram_idx;
    logic                out_of_range;
    logic                access_now;
    logic                ram_we;

    // The RAM index and the range check always come from MAR. MAR is frozen
    // outside IDLE, so a MAR load on the same edge as a request is already
    // visible when the access happens in WAIT.
    assign ram_idx      = mar_q[ADDR_W-1:0];
    assign out_of_range = |mar_q[DATA_W-1:ADDR_W];
    assign access_now   = (state_q == ST_WAIT) && (cnt_q == 4'd0);

    // clr wins over a pending access, so an aborted write never reaches
    // the RAM.
    assign ram_we = !clr && access_now && op_wr_q && !out_of_range;

`ifdef MEM_PRELOAD_EN
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram_q[i] = '0;
        end
        ram_q[0] = DATA_W'(32'h00000A5A);
    end
`else
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram_q[i] = '0;
        end
    end
`endif

    // RAM write port. clr does not touch the contents.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= wdata_q;
        end
    end

    // Transaction FSM. All outputs are registered. They are set on the edge
    // that enters the state in which they must be seen.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            wdata_q <= '0;
            mar_q   <= '0;
            mdat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            aerr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (MARin) begin
                        mar_q <= bus_contents;
                    end
                    if (Read && Write) begin
                        // Illegal request: complete at once with an error
                        // and no RAM access.
                        state_q <= ST_DONE;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b1;
                        aerr_q  <= 1'b1;
                    end else if (Read || Write) begin
                        op_wr_q <= Write;
                        wdata_q <= MDR_data_out;
                        cnt_q   <= 4'(WAIT_STATES);
                        state_q <= ST_WAIT;
                        busy_q  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        aerr_q  <= out_of_range;
                        if (!op_wr_q) begin
                            mdat_q <= out_of_range ? '0 : ram_q[ram_idx];
                        end
                    end
                end
                ST_DONE: begin
                    // Requests seen here are dropped, not queued.
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign MDatain      = mdat_q;
    assign MAR_data_out = mar_q;
    assign mem_busy     = busy_q;
    assign mem_done     = done_q;
    assign addr_err     = aerr_q;

endmodule

// File: tb/tb_mem_interface.sv
// ---------------------------------------------------------------------------
// tb_mem_interface
//
// Self-checking bench for mem_interface. The reference model is a plain
// array holding the RAM contents, plus the expected MAR and MDatain values.
// Expected results are worked out from the transaction rules: the latency
// follows from WAIT_STATES, and the error cases come from the request type
// and the MAR range.
// ---------------------------------------------------------------------------
module tb_mem_interface;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;
    localparam int WS     = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              clr;
    logic [DATA_W-1:0] bus_contents;
    logic              MARin;
    logic [DATA_W-1:0] MDR_data_out;
    logic              Read;
    logic              Write;
    logic [DATA_W-1:0] MDatain;
    logic [DATA_W-1:0] MAR_data_out;
    logic              mem_busy;
    logic              mem_done;
    logic              addr_err;

    mem_interface #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .WAIT_STATES (WS)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .bus_contents (bus_contents),
        .MARin        (MARin),
        .MDR_data_out (MDR_data_out),
        .Read         (Read),
        .Write        (Write),
        .MDatain      (MDatain),
        .MAR_data_out (MAR_data_out),
        .mem_busy     (mem_busy),
        .mem_done     (mem_done),
        .addr_err     (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
    logic [DATA_W-1:0] ref_mar;
    logic [DATA_W-1:0] exp_mdat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_mar(input logic [31:0] v);
        MARin        = 1'b1;
        bus_contents = v;
        @(negedge clk);
        MARin        = 1'b0;
        bus_contents = $urandom;
        ref_mar      = v;
        check("mar_load", MAR_data_out, ref_mar);
    endtask

    // Issues one request at the current negedge and checks its completion.
    // ld: load MAR on the same edge that accepts the request.
    // disturb: while in WAIT, pulse MARin (bus=0x55) and Write; both must be
    // ignored.
    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] wd,
                          input bit ld, input logic [31:0] ldv,
                          input bit disturb, input string tag);
        int k;
        int extra;
        int exp_k;
        bit got;
        bit exp_err;
        bit oor;
        Read         = rd;
        Write        = wr;
        MDR_data_out = wd;
        if (ld) begin
            MARin        = 1'b1;
            bus_contents = ldv;
            ref_mar      = ldv;
        end
        if (rd && wr) begin
            exp_k   = 1;
            exp_err = 1'b1;
        end else begin
            exp_k   = WS + 2;
            oor     = (ref_mar[DATA_W-1:ADDR_W] != '0);
            exp_err = oor;
            if (rd) begin
                exp_mdat = oor ? '0 : ref_mem[ref_mar[ADDR_W-1:0]];
            end else if (!oor) begin
                ref_mem[ref_mar[ADDR_W-1:0]] = wd;
            end
        end
        k   = 0;
        got = 1'b0;
        while (!got && k < 16) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                Read         = 1'b0;
                Write        = 1'b0;
                MARin        = 1'b0;
                MDR_data_out = $urandom;
                check({tag, "_busy"}, {31'd0, mem_busy}, 32'd1);
                if (disturb) begin
                    MARin        = 1'b1;
                    bus_contents = 32'h55;
                    Write        = 1'b1;
                end
            end else if (k == 2 && disturb) begin
                MARin = 1'b0;
                Write = 1'b0;
            end
            if (mem_done === 1'b1) got = 1'b1;
        end
        check({tag, "_latency"}, 32'(k), 32'(exp_k));
        check({tag, "_addr_err"}, {31'd0, addr_err}, {31'd0, exp_err});
        check({tag, "_mdatain"}, MDatain, exp_mdat);
        check({tag, "_mar"}, MAR_data_out, ref_mar);
        extra = 0;
        repeat (disturb ? 6 : 1) begin
            @(negedge clk);
            if (mem_done === 1'b1) extra++;
        end
        check({tag, "_single_done"}, 32'(extra), 32'd0);
        check({tag, "_idle"}, {31'd0, mem_busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int extra;
        logic [31:0] a;
        int r;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`ifdef MEM_PRELOAD_EN
        ref_mem[0] = 32'h00000A5A;
`endif
        ref_mar      = '0;
        exp_mdat     = '0;
        clr          = 1'b1;
        bus_contents = '0;
        MARin        = 1'b0;
        MDR_data_out = '0;
        Read         = 1'b0;
        Write        = 1'b0;

        // Reset
        repeat (2) @(negedge clk);
        clr = 1'b0;
        check("rst_mar", MAR_data_out, 32'd0);
        check("rst_mdatain", MDatain, 32'd0);
        check("rst_busy", {31'd0, mem_busy}, 32'd0);
        check("rst_done", {31'd0, mem_done}, 32'd0);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);
        @(negedge clk);

        // Preload word 0 (zero without the preload build)
        do_txn(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "preload_rd");

        // Write then read back
        set_mar(32'h12);
        do_txn(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, "wr12");
        do_txn(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "rd12");

        // Busy / ignore, then confirm that RAM[0x55] is unchanged
        do_txn(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "busy_rd");
        set_mar(32'h55);
        do_txn(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "rd55");

        // Illegal request, then a read of 0x12 to show the RAM is unchanged
        set_mar(32'h12);
        do_txn(1'b1, 1'b1, 32'h11111111, 1'b0, 32'h0, 1'b0, "illegal");
        do_txn(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "rd12_after_ill");

        // Out-of-range read and write (the write must not alias to word 0)
        set_mar(32'h200);
        do_txn(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "oor_rd");
        do_txn(1'b0, 1'b1, 32'h77777777, 1'b0, 32'h0, 1'b0, "oor_wr");
        do_txn(1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, "rd0_after_oor");

        // Reset in the middle of a write
        set_mar(32'h20);
        Write        = 1'b1;
        MDR_data_out = 32'hCAFEF00D;
        @(negedge clk);
        Write = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr      = 1'b0;
        ref_mar  = '0;
        exp_mdat = '0;
        extra    = 0;
        repeat (8) begin
            @(negedge clk);
            if (mem_done === 1'b1) extra++;
        end
        check("abort_no_done", 32'(extra), 32'd0);
        check("abort_idle", {31'd0, mem_busy}, 32'd0);
        check("abort_mar", MAR_data_out, 32'd0);
        set_mar(32'h20);
        do_txn(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "rd20_after_abort");

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 7);
            a = {26'd0, 6'($urandom_range(0, 63))};
            if (r == 0) a = 32'h200 | a;
            else if (r == 1) a = 32'h80000000 | a;
            r = $urandom_range(0, 3);
            if (r == 0) set_mar(a);
            r = $urandom_range(0, 9);
            do_txn(r <= 4, (r == 0) || (r >= 5), $urandom, $urandom_range(0, 2) == 0, a,
                   1'b0, "rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
